// File: rtl/uart_hex_rx.sv
// Hex line assembler: pops ASCII from the UART RX FIFO and
// streams each CR/LF-terminated line to control as one binary packet.
module uart_hex_rx #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [7:0]       i_rdata,
  input  logic             i_rready,
  output logic             o_rreq,
  output logic [7:0]       o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready,
  output logic [LEN_W-1:0] o_len,
  output logic             o_err,
  output logic             o_busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    COLLECT,
    DISCARD,
    EMIT
  } state_t;

  state_t state, state_n;

  logic [7:0]       mem [MAX_LEN];
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] idx;
  logic [3:0]       hi;
  logic [3:0]       nib;
  logic             phase_lo;

  logic c_hex, c_term, c_space;
  logic in_col, pop, xfer;
  logic ev_hi, ev_pair, ev_full, ev_bad;
  logic ev_odd, ev_emit, ev_done;

  always_comb begin
    c_hex = 1'b0;
    nib   = 4'h0;
    unique case (1'b1)
      (i_rdata >= 8'h30 && i_rdata <= 8'h39): begin
        c_hex = 1'b1;
        nib   = i_rdata[3:0];
      end
      ((i_rdata >= 8'h41 && i_rdata <= 8'h46) ||
       (i_rdata >= 8'h61 && i_rdata <= 8'h66)): begin
        c_hex = 1'b1;
        nib   = i_rdata[3:0] + 4'd9;
      end
      default: ;
    endcase
  end

  assign c_term  = (i_rdata == 8'h0D) | (i_rdata == 8'h0A);
  assign c_space = (i_rdata == 8'h20);

  assign in_col  = (state == COLLECT);
  assign pop     = o_rreq;
  assign xfer    = o_valid & i_ready;

  assign ev_hi   = in_col & pop & c_hex & ~phase_lo;
  assign ev_pair = in_col & pop & c_hex & phase_lo;
  assign ev_full = ev_pair & (count == LEN_W'(MAX_LEN));
  // a space is only legal between complete pairs
  assign ev_bad  = in_col & pop & ~c_hex & ~c_term
                 & ~(c_space & ~phase_lo);
  assign ev_odd  = in_col & pop & c_term & phase_lo;
  assign ev_emit = in_col & pop & c_term & ~phase_lo
                 & (count != '0);
  assign ev_done = xfer & o_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= COLLECT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      COLLECT: begin
        if (ev_bad | ev_full) state_n = DISCARD;
        else if (ev_emit)     state_n = EMIT;
      end
      DISCARD: begin
        if (pop & c_term) state_n = COLLECT;
      end
      EMIT: begin
        if (ev_done) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  always_comb begin
    o_rreq  = i_rready & (state == COLLECT | state == DISCARD);
    o_valid = (state == EMIT);
    o_data  = o_valid ? mem[idx[AW-1:0]] : 8'h00;
    o_last  = o_valid & (idx == o_len - LEN_W'(1));
    o_busy  = (state != COLLECT) | (count != '0) | phase_lo;
  end

  always_ff @(posedge i_clk) begin
    if (ev_pair & ~ev_full) mem[count[AW-1:0]] <= {hi, nib};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count    <= '0;
      idx      <= '0;
      hi       <= 4'h0;
      phase_lo <= 1'b0;
      o_len    <= '0;
      o_err    <= 1'b0;
    end else begin
      o_err <= ev_bad | ev_full | ev_odd;
      unique case (state)
        COLLECT: begin
          if (ev_odd) begin
            count    <= '0;
            phase_lo <= 1'b0;
          end else if (ev_emit) begin
            o_len <= count;
            idx   <= '0;
          end else if (ev_hi) begin
            hi       <= nib;
            phase_lo <= 1'b1;
          end else if (ev_pair & ~ev_full) begin
            count    <= count + LEN_W'(1);
            phase_lo <= 1'b0;
          end
        end
        DISCARD: begin
          if (pop & c_term) begin
            count    <= '0;
            phase_lo <= 1'b0;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (o_last) begin
              count    <= '0;
              phase_lo <= 1'b0;
              idx      <= '0;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_rx.sv
// Bench for uart_hex_rx: FIFO feeder, packet monitor and a
// line-level reference model of the hex framing rules.
module tb_uart_hex_rx;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic             i_clk    = 1'b0;
  logic             i_rst    = 1'b1;
  logic [7:0]       i_rdata  = 8'h00;
  logic             i_rready = 1'b0;
  logic             i_ready  = 1'b0;
  logic             o_rreq;
  logic [7:0]       o_data;
  logic             o_valid;
  logic             o_last;
  logic [LEN_W-1:0] o_len;
  logic             o_err;
  logic             o_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo[$];
  logic [7:0] stim[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         rx_lens[$];
  int         exp_lens[$];

  int err_seen = 0;
  int exp_err  = 0;
  int pops     = 0;
  int cyc      = 0;
  int pkt_cnt  = 0;
  int rdy_mode = 0;

  logic             will_pop   = 1'b0;
  logic             stall_prev = 1'b0;
  logic [7:0]       hold_d     = 8'h00;
  logic             hold_l     = 1'b0;
  logic [LEN_W-1:0] hold_n     = '0;

  uart_hex_rx #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rdata (i_rdata),
    .i_rready(i_rready),
    .o_rreq  (o_rreq),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .i_ready (i_ready),
    .o_len   (o_len),
    .o_err   (o_err),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO side: pop on the edge, then present the new head
  always @(posedge i_clk) begin
    logic [7:0] dummy;
    if (will_pop && fifo.size() != 0) begin
      dummy = fifo.pop_front();
      pops++;
    end
    #1;
    cyc++;
    i_rready = (fifo.size() != 0);
    i_rdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      2:       i_ready = (cyc % 3 == 0);
      default: i_ready = 1'b0;
    endcase
  end

  always @(negedge i_clk) begin
    will_pop = o_rreq;
    if (i_rst) begin
      stall_prev = 1'b0;
      pkt_cnt    = 0;
    end else begin
      if (o_err) begin
        err_seen++;
        chk("err_in_emit", 32'(o_valid), 32'd0);
      end
      if (o_valid) chk("rreq_in_emit", 32'(o_rreq), 32'd0);
      if (stall_prev) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(o_data), 32'(hold_d));
        chk("hold_last", 32'(o_last), 32'(hold_l));
        chk("hold_len", 32'(o_len), 32'(hold_n));
      end
      stall_prev = o_valid & ~i_ready;
      hold_d     = o_data;
      hold_l     = o_last;
      hold_n     = o_len;
      if (o_valid && i_ready) begin
        rx_q.push_back(o_data);
        pkt_cnt++;
        if (o_last) begin
          chk("len_at_last", 32'(o_len), 32'(pkt_cnt));
          rx_lens.push_back(int'(o_len));
          pkt_cnt = 0;
        end else begin
          chk("last_missing", 32'(pkt_cnt < int'(o_len)), 32'd1);
        end
      end
    end
  end

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [7:0] hexch(input int n);
    string hx;
    hx = "0123456789ABCDEF";
    return hx[n];
  endfunction

  // Split the stream into lines and judge each line as a whole
  function automatic void model();
    int         nd;
    int         hv;
    bit         dead;
    logic [3:0] hn;
    logic [7:0] lb[$];
    nd   = 0;
    dead = 1'b0;
    hn   = 4'h0;
    foreach (stim[i]) begin
      logic [7:0] c;
      c = stim[i];
      if (c == 8'h0A || c == 8'h0D) begin
        if (!dead) begin
          if (nd % 2 == 1) exp_err++;
          else if (nd > 0) begin
            foreach (lb[j]) exp_q.push_back(lb[j]);
            exp_lens.push_back(nd / 2);
          end
        end
        nd   = 0;
        dead = 1'b0;
        lb.delete();
      end else if (!dead) begin
        hv = hexval(c);
        if (hv >= 0) begin
          nd++;
          if (nd % 2 == 1) hn = hv[3:0];
          else if (nd / 2 > MAX_LEN) begin
            exp_err++;
            dead = 1'b1;
          end else lb.push_back({hn, hv[3:0]});
        end else if (!(c == 8'h20 && nd % 2 == 0)) begin
          exp_err++;
          dead = 1'b1;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (!(fifo.size() == 0 && !o_busy && !o_valid) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
    tick();
    tick();
  endtask

  task automatic compare();
    chk("npkt", 32'(rx_lens.size()), 32'(exp_lens.size()));
    foreach (exp_lens[i])
      chk("pkt_len", (i < rx_lens.size()) ? 32'(rx_lens[i]) : 32'hFFFF_FFFF,
          32'(exp_lens[i]));
    chk("nbytes", 32'(rx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      chk("byte", (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF,
          32'(exp_q[i]));
    chk("nerr", 32'(err_seen), 32'(exp_err));
    rx_q.delete();
    exp_q.delete();
    rx_lens.delete();
    exp_lens.delete();
  endtask

  task automatic go();
    model();
    foreach (stim[i]) fifo.push_back(stim[i]);
    stim.delete();
    wait_idle();
    compare();
  endtask

  initial begin
    int         p0;
    int         n;
    int         r;
    int         nl;
    logic [7:0] c;
    logic [7:0] badc[4];
    string      hx;
    badc = '{8'h47, 8'h3A, 8'hC1, 8'h7F};
    hx   = "0123456789abcdefABCDEF";

    i_rst = 1'b1;
    repeat (3) tick();
    chk("rst_rreq", 32'(o_rreq), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_len", 32'(o_len), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    tick();
    chk("idle_busy", 32'(o_busy), 32'd0);

    rdy_mode = 0;
    p0 = pops;
    add_str("0aFF\n");
    go();
    chk("pops_0aFF", 32'(pops - p0), 32'd5);

    add_str("12 34\r\n");
    go();

    add_str("1G23\nAB\n");
    go();

    add_str("123\n");
    go();

    for (int i = 0; i < MAX_LEN + 1; i++) add_str("12");
    add_str("\n");
    go();

    for (int i = 0; i < MAX_LEN; i++) begin
      stim.push_back(hexch(i / 16));
      stim.push_back(hexch(i % 16));
    end
    add_str("\r\n");
    go();

    add_str(" \n \r1 2\n");
    stim.push_back(8'hB1);
    add_str("2\nC3\n");
    go();

    rdy_mode = 2;
    add_str("DEADBEEF\n55\n");
    go();

    // reset in the middle of a packet
    rdy_mode = 3;
    add_str("A1B2C3D4\n");
    foreach (stim[i]) fifo.push_back(stim[i]);
    stim.delete();
    n = 0;
    while (!o_valid && n < 200) begin
      tick();
      n++;
    end
    chk("emit_timeout", 32'(n < 200), 32'd1);
    rdy_mode = 0;
    tick();
    tick();
    rdy_mode = 3;
    tick();
    i_rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_len", 32'(o_len), 32'd0);
    i_rst = 1'b0;
    chk("mid_rst_nbytes", 32'(rx_q.size()), 32'd2);
    chk("mid_rst_b0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'hA1);
    chk("mid_rst_b1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hFFFF_FFFF, 32'hB2);
    rx_q.delete();
    rx_lens.delete();
    rdy_mode = 0;
    tick();
    add_str("55\n");
    go();

    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        n = $urandom_range(0, 12);
        for (int k = 0; k < n; k++) begin
          r = $urandom_range(0, 99);
          if (r < 78) c = hx[$urandom_range(0, 21)];
          else if (r < 92) c = 8'h20;
          else c = badc[$urandom_range(0, 3)];
          stim.push_back(c);
        end
        r = $urandom_range(0, 2);
        if (r == 0) add_str("\n");
        else if (r == 1) add_str("\r");
        else add_str("\r\n");
      end
      go();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
